regfile_dump: RTL and testbench

REGFILE_DUMP -- requirements
Module: regfile_dump

---
 rtl/regfile_dump.sv | 142 ++++++++++++++
 tb/tb_regfile_dump.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump.sv
// regfile_dump: walks a 32-entry register file two registers at a time and
// streams every register out over a valid/ready interface, lowest index first.
// Each pair is read once into local buffers, so later register-file writes
// never disturb values already captured.
module regfile_dump #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [4:0]            rs,
  output logic [4:0]            rt,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [4:0]            out_idx,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StRead  = 3'd1,
    StSendA = 3'd2,
    StSendB = 3'd3,
    StDone  = 3'd4
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [3:0]            r_k;
  logic [3:0]            w_k_next;
  logic [3:0]            w_k_inc;
  logic [4:0]            r_rs;
  logic [4:0]            w_rs_next;
  logic [4:0]            r_rt;
  logic [4:0]            w_rt_next;
  logic [DATA_WIDTH-1:0] r_buf_a;
  logic [DATA_WIDTH-1:0] r_buf_b;
  logic                  w_load_bufs;
  logic                  w_xfer;
  logic                  w_last_pair;

  assign w_xfer      = out_valid & out_ready;
  assign w_k_inc     = r_k + 4'd1;
  assign w_last_pair = (r_k == 4'd15);

  // Next-state logic: pair counter, read addresses and buffer load strobe.
  always_comb begin
    w_state_next = r_state;
    w_k_next     = r_k;
    w_rs_next    = r_rs;
    w_rt_next    = r_rt;
    w_load_bufs  = 1'b0;
    unique case (r_state)
      StIdle: begin
        // start is only honoured here, so pulses during a dump are dropped.
        if (start) begin
          w_state_next = StRead;
          w_k_next     = 4'd0;
          w_rs_next    = 5'd0;
          w_rt_next    = 5'd1;
        end
      end
      StRead: begin
        // Register-file read data is sampled at the closing edge of this cycle.
        w_load_bufs  = 1'b1;
        w_state_next = StSendA;
      end
      StSendA: begin
        if (w_xfer) begin
          w_state_next = StSendB;
        end
      end
      StSendB: begin
        if (w_xfer) begin
          if (w_last_pair) begin
            w_state_next = StDone;
          end else begin
            w_state_next = StRead;
            w_k_next     = w_k_inc;
            w_rs_next    = {w_k_inc, 1'b0};
            w_rt_next    = {w_k_inc, 1'b1};
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State, counter and address registers; reset clears everything at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_k     <= 4'd0;
      r_rs    <= 5'd0;
      r_rt    <= 5'd0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_rs    <= w_rs_next;
      r_rt    <= w_rt_next;
    end
  end

  // Snapshot buffers for the current pair, loaded only at the READ edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf_a <= '0;
      r_buf_b <= '0;
    end else if (w_load_bufs) begin
      r_buf_a <= a;
      r_buf_b <= b;
    end
  end

  // Output decode; buffers and counter are zero in reset so data/idx read 0 too.
  always_comb begin
    rs        = r_rs;
    rt        = r_rt;
    out_valid = 1'b0;
    out_data  = r_buf_a;
    out_idx   = {r_k, 1'b0};
    busy      = (r_state != StIdle);
    done      = (r_state == StDone);
    if (r_state == StSendA) begin
      out_valid = 1'b1;
    end else if (r_state == StSendB) begin
      out_valid = 1'b1;
      out_data  = r_buf_b;
      out_idx   = {r_k, 1'b1};
    end
  end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: behavioural register file, cycle table for the
// first cycles of a dump, then full dumps under several ready/start patterns.
module tb_regfile_dump;

  logic        clk;
  logic        rst;
  logic        start;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;

  logic [31:0] regs     [32];
  logic [31:0] exp_data [32];

  int checks = 0;
  int errors = 0;

  assign a = regs[rs];
  assign b = regs[rt];

  regfile_dump #(.DATA_WIDTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rs       (rs),
    .rt       (rt),
    .a        (a),
    .b        (b),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic        st;
    logic        rdy;
    logic        busy;
    logic        valid;
    logic [4:0]  idx;
    logic [31:0] data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        done;
  } vec_t;

  vec_t vecs [9];

  // Full dump. mode 0: ready high; 1: ready 1 high / 2 low; 2: ready high with
  // start pulsed throughout; 3: ready high, reg3 written during pair 1 SEND_A.
  task automatic run_dump(input int mode, input int exp_done_cyc);
    int          n;
    int          cyc;
    int          done_cyc;
    bit          seen_done;
    bit          wrote;
    logic        held_v;
    logic [4:0]  held_i;
    logic [31:0] held_d;
    n = 0; done_cyc = 0; seen_done = 0; wrote = 0;
    held_v = 1'b0; held_i = '0; held_d = '0;
    start     = 1'b1;
    out_ready = (mode != 1);
    @(negedge clk);
    start = 1'b0;
    cyc   = 1;
    while (cyc < 400 && !seen_done) begin
      if (mode == 2) start = cyc[0];
      if (mode == 1) out_ready = ((cyc % 3) == 0);
      #1;
      if (done) begin
        seen_done = 1;
        done_cyc  = cyc;
        chk("done_no_valid", {31'd0, out_valid}, 32'd0);
      end
      if (held_v) begin
        chk("valid_held", {31'd0, out_valid}, 32'd1);
        if (out_valid) begin
          chk("stall_idx_stable", {27'd0, out_idx}, {27'd0, held_i});
          chk("stall_data_stable", out_data, held_d);
        end
      end
      if (out_valid) begin
        if (mode == 3 && out_idx == 5'd2 && !wrote) begin
          regs[3] = 32'd7777;
          wrote   = 1;
        end
        if (out_ready) begin
          if (n < 32) begin
            chk("xfer_idx", {27'd0, out_idx}, n);
            chk("xfer_data", out_data, exp_data[n]);
          end else begin
            chk("extra_xfer_count", n, 31);
          end
          n++;
          held_v = 1'b0;
        end else begin
          held_v = 1'b1;
          held_i = out_idx;
          held_d = out_data;
        end
      end
      @(negedge clk);
      cyc++;
    end
    start     = 1'b0;
    out_ready = 1'b1;
    chk("done_seen", {31'd0, seen_done}, 32'd1);
    chk("xfer_total", n, 32);
    if (exp_done_cyc > 0) chk("done_cycle", done_cyc, exp_done_cyc);
    // Single done pulse, back to idle, nothing restarted.
    #1;
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    @(negedge clk);
    #1;
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bit found;
    rst       = 1'b1;
    start     = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'd0;
    regs[31] = 32'd2001;
    regs[2]  = 32'd4001;
    regs[30] = 32'd5001;
    regs[8]  = 32'd3001;
    for (int i = 0; i < 32; i++) exp_data[i] = regs[i];

    //             st    rdy   busy  valid idx   data        rs    rt    done
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,    5'd0, 5'd0, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0,    5'd0, 5'd0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,    5'd0, 5'd1, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 32'd0,    5'd0, 5'd1, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b1, 5'd0, 32'd0,    5'd0, 5'd1, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 5'd1, 32'd0,    5'd0, 5'd1, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0,    5'd2, 5'd3, 1'b0};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'd4001, 5'd2, 5'd3, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'd4001, 5'd2, 5'd3, 1'b0};

    // Reset values appear without any clock edge.
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    chk("rst_out_idx", {27'd0, out_idx}, 32'd0);
    chk("rst_rs", {27'd0, rs}, 32'd0);
    chk("rst_rt", {27'd0, rt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Cycle-by-cycle start of a dump with stalls and an ignored start.
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      start     = vecs[i].st;
      out_ready = vecs[i].rdy;
      #1;
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, vecs[i].busy});
      chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].valid});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, vecs[i].done});
      chk($sformatf("vec%0d_rs", i), {27'd0, rs}, {27'd0, vecs[i].rs});
      chk($sformatf("vec%0d_rt", i), {27'd0, rt}, {27'd0, vecs[i].rt});
      if (vecs[i].valid) begin
        chk($sformatf("vec%0d_idx", i), {27'd0, out_idx}, {27'd0, vecs[i].idx});
        chk($sformatf("vec%0d_data", i), out_data, vecs[i].data);
      end
    end

    // Abort the partial dump asynchronously.
    #2 rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_rs", {27'd0, rs}, 32'd0);
    @(negedge clk);
    rst       = 1'b0;
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);

    run_dump(0, 49);
    run_dump(1, 0);
    run_dump(2, 49);
    run_dump(0, 49);

    // Write after pair 1 is buffered: old value streams now, new value next time.
    run_dump(3, 49);
    exp_data[3] = 32'd7777;
    run_dump(0, 49);

    // Reset during SEND_B of pair 5, then restart from register 0.
    start     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && !found; c++) begin
      #1;
      if (out_valid && out_idx == 5'd11) found = 1;
      else @(negedge clk);
    end
    chk("reach_pair5_sendb", {31'd0, found}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_out_idx", {27'd0, out_idx}, 32'd0);
    chk("midrst_out_data", out_data, 32'd0);
    chk("midrst_rt", {27'd0, rt}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      chk("after_abort_done", {31'd0, done}, 32'd0);
      chk("after_abort_busy", {31'd0, busy}, 32'd0);
    end
    @(negedge clk);
    run_dump(0, 49);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
